accumulator_datapath: RTL and testbench

//  Execute-stage datapath for the 16-bit accumulator processor: holds ACC, zero and carry flags.

---
 rtl/dp_pkg.sv | 18 +
 rtl/opcodes.sv | 20 ++
 rtl/shift_add_multiplier.sv | 83 ++++++++
 rtl/accumulator_datapath.sv | 126 ++++++++++++
 tb/tb_accumulator_datapath.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared types and sizing for the accumulator datapath and its multiplier.
package dp_pkg;

    localparam int DP_WIDTH      = 16;
    localparam int DP_MUL_CYCLES = DP_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/opcodes.sv
// Opcode encodings shared by the control unit and the execute-stage datapath.
package opcodes_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDA   = 4'h1;
    localparam logic [3:0] OP_STA   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JMPZ  = 4'hC;
    localparam logic [3:0] OP_JMPNZ = 4'hD;
    localparam logic [3:0] OP_MUL   = 4'hE;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: one partial product per cycle, full 2*WIDTH product.
module shift_add_multiplier
    import dp_pkg::*;
#(
    parameter int WIDTH      = DP_WIDTH,
    parameter int MUL_CYCLES = DP_MUL_CYCLES
) (
    input  logic               clock,
    input  logic               not_reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    mul_state_t         state;
    mul_state_t         next_state;
    logic [2*WIDTH-1:0] mcand_sh;
    logic [WIDTH-1:0]   mplier_sh;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      count;

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // blocking here would let later statements see already-updated state.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: the operand/product registers are reset too, so an aborted MUL
    // leaves nothing behind that a later DONE could expose.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            mcand_sh  <= '0;
            mplier_sh <= '0;
            prod      <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_sh  <= {{WIDTH{1'b0}}, multiplicand};
                        mplier_sh <= multiplier;
                        prod      <= '0;
                        count     <= CW'(MUL_CYCLES);
                    end
                end
                RUN: begin
                    if (mplier_sh[0]) begin
                        prod <= prod + mcand_sh;
                    end
                    mcand_sh  <= mcand_sh << 1;
                    mplier_sh <= mplier_sh >> 1;
                    count     <= count - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == CW'(1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = prod;

endmodule

// File: rtl/accumulator_datapath.sv
// Execute-stage datapath: accumulator, zero/carry flags, single-cycle ALU and multi-cycle MUL.
module accumulator_datapath
    import dp_pkg::*;
    import opcodes_pkg::*;
#(
    parameter int WIDTH      = DP_WIDTH,
    parameter int MUL_CYCLES = DP_MUL_CYCLES
) (
    input  logic             clock,
    input  logic             not_reset,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             zflag,
    output logic             cflag,
    output logic             busy
);

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    flags_t             flags;
    flags_t             flags_next;
    logic               acc_write;
    logic [WIDTH:0]     wide;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // A MUL is only accepted from idle; while busy the opcode bus is ignored.
    assign mul_start = (operation == OP_MUL) && !mul_busy;

    shift_add_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock        (clock),
        .not_reset    (not_reset),
        .start        (mul_start),
        .multiplicand (data_in),
        .multiplier   (acc),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );

    always_comb begin
        acc_next   = acc;
        flags_next = flags;
        acc_write  = 1'b0;
        wide       = '0;
        if (mul_done) begin
            acc_next     = mul_product[WIDTH-1:0];
            flags_next.c = |mul_product[2*WIDTH-1:WIDTH];
            acc_write    = 1'b1;
        end else if (!mul_busy) begin
            case (operation)
                OP_LDA: begin
                    acc_next  = data_in;
                    acc_write = 1'b1;
                end
                OP_ADD: begin
                    wide         = {1'b0, acc} + {1'b0, data_in};
                    acc_next     = wide[WIDTH-1:0];
                    flags_next.c = wide[WIDTH];
                    acc_write    = 1'b1;
                end
                OP_SUB: begin
                    // Top bit of the extended difference is the unsigned borrow.
                    wide         = {1'b0, acc} - {1'b0, data_in};
                    acc_next     = wide[WIDTH-1:0];
                    flags_next.c = wide[WIDTH];
                    acc_write    = 1'b1;
                end
                OP_AND: begin
                    acc_next  = acc & data_in;
                    acc_write = 1'b1;
                end
                OP_OR: begin
                    acc_next  = acc | data_in;
                    acc_write = 1'b1;
                end
                OP_XOR: begin
                    acc_next  = acc ^ data_in;
                    acc_write = 1'b1;
                end
                OP_NOT: begin
                    acc_next  = ~acc;
                    acc_write = 1'b1;
                end
                OP_SHL: begin
                    acc_next     = {acc[WIDTH-2:0], 1'b0};
                    flags_next.c = acc[WIDTH-1];
                    acc_write    = 1'b1;
                end
                OP_SHR: begin
                    acc_next     = {1'b0, acc[WIDTH-1:1]};
                    flags_next.c = acc[0];
                    acc_write    = 1'b1;
                end
                OP_STA, OP_NOP, OP_JMP, OP_JMPZ, OP_JMPNZ, OP_MUL: ;
                default: ;
            endcase
        end
        if (acc_write) begin
            flags_next.z = (acc_next == '0);
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            acc     <= '0;
            flags.z <= 1'b1;
            flags.c <= 1'b0;
        end else begin
            acc   <= acc_next;
            flags <= flags_next;
        end
    end

    assign data_out = acc;
    assign zflag    = flags.z;
    assign cflag    = flags.c;
    assign busy     = mul_busy;

endmodule

// File: tb/tb_accumulator_datapath.sv
// Directed, table-driven bench for accumulator_datapath with hand-written MUL and reset sequences.
module tb_accumulator_datapath;
    import opcodes_pkg::*;

    logic        clock;
    logic        not_reset;
    logic [3:0]  operation;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        zflag;
    logic        cflag;
    logic        busy;

    int errors = 0;
    int checks = 0;

    accumulator_datapath dut (
        .clock     (clock),
        .not_reset (not_reset),
        .operation (operation),
        .data_in   (data_in),
        .data_out  (data_out),
        .zflag     (zflag),
        .cflag     (cflag),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] data;
        logic [15:0] exp_acc;
        logic        exp_z;
        logic        exp_c;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] a, input logic z, input logic c,
                               input logic b);
        check({tag, " acc"}, 32'(data_out), 32'(a));
        check({tag, " z"}, 32'(zflag), 32'(z));
        check({tag, " c"}, 32'(cflag), 32'(c));
        check({tag, " busy"}, 32'(busy), 32'(b));
    endtask

    // Called at a negedge; drives one opcode across one rising edge, returns at the next negedge.
    task automatic apply(input logic [3:0] op, input logic [15:0] d);
        operation = op;
        data_in   = d;
        @(posedge clock);
        @(negedge clock);
        operation = OP_NOP;
        data_in   = 16'h0000;
    endtask

    // Issues MUL with the current ACC as multiplier, counts busy cycles while scrambling the bus.
    task automatic do_mul(input string tag, input logic [15:0] d, input logic [15:0] exp_acc,
                          input logic exp_z, input logic exp_c);
        int n;
        logic [3:0] junk_ops [4];
        junk_ops[0] = OP_MUL;
        junk_ops[1] = OP_LDA;
        junk_ops[2] = OP_ADD;
        junk_ops[3] = OP_NOT;
        n = 0;
        operation = OP_MUL;
        data_in   = d;
        @(posedge clock);
        @(negedge clock);
        while (busy && n < 40) begin
            n++;
            operation = junk_ops[n % 4];
            data_in   = 16'($urandom);
            @(posedge clock);
            @(negedge clock);
        end
        operation = OP_NOP;
        data_in   = 16'h0000;
        check({tag, " busy cycles"}, 32'(n), 32'd17);
        check_state(tag, exp_acc, exp_z, exp_c, 1'b0);
    endtask

    initial begin
        not_reset = 1'b0;
        operation = OP_NOP;
        data_in   = 16'h0000;
        repeat (2) @(negedge clock);
        check_state("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        not_reset = 1'b1;
        @(negedge clock);

        vecs = '{
            '{OP_LDA,   16'h0000, 16'h0000, 1'b1, 1'b0},
            '{OP_LDA,   16'hFFFF, 16'hFFFF, 1'b0, 1'b0},
            '{OP_ADD,   16'h0001, 16'h0000, 1'b1, 1'b1},
            '{OP_SUB,   16'h0001, 16'hFFFF, 1'b0, 1'b1},
            '{OP_SUB,   16'hFFFF, 16'h0000, 1'b1, 1'b0},
            '{OP_LDA,   16'h8001, 16'h8001, 1'b0, 1'b0},
            '{OP_SHL,   16'h0000, 16'h0002, 1'b0, 1'b1},
            '{OP_SHR,   16'h0000, 16'h0001, 1'b0, 1'b0},
            '{OP_NOT,   16'h0000, 16'hFFFE, 1'b0, 1'b0},
            '{OP_AND,   16'h00FF, 16'h00FE, 1'b0, 1'b0},
            '{OP_OR,    16'h0F01, 16'h0FFF, 1'b0, 1'b0},
            '{OP_XOR,   16'h0FFF, 16'h0000, 1'b1, 1'b0},
            '{OP_LDA,   16'h1234, 16'h1234, 1'b0, 1'b0},
            '{OP_ADD,   16'hF000, 16'h0234, 1'b0, 1'b1},
            '{OP_NOT,   16'h0000, 16'hFDCB, 1'b0, 1'b1},
            '{OP_LDA,   16'h1234, 16'h1234, 1'b0, 1'b1},
            '{OP_STA,   16'h0000, 16'h1234, 1'b0, 1'b1},
            '{OP_JMP,   16'hFFFF, 16'h1234, 1'b0, 1'b1},
            '{OP_JMPZ,  16'h0000, 16'h1234, 1'b0, 1'b1},
            '{OP_JMPNZ, 16'h0005, 16'h1234, 1'b0, 1'b1},
            '{OP_NOP,   16'h0009, 16'h1234, 1'b0, 1'b1},
            '{4'hF,     16'h0001, 16'h1234, 1'b0, 1'b1},
            '{OP_LDA,   16'h0000, 16'h0000, 1'b1, 1'b1},
            '{OP_JMPZ,  16'h0000, 16'h0000, 1'b1, 1'b1}
        };
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].data);
            check_state($sformatf("vec%0d", i), vecs[i].exp_acc, vecs[i].exp_z, vecs[i].exp_c, 1'b0);
        end

        // 300 * 200 = 60000 fits in 16 bits.
        apply(OP_LDA, 16'd300);
        do_mul("mul300x200", 16'd200, 16'hEA60, 1'b0, 1'b0);

        // 0x100 * 0x100 overflows into the upper half only.
        apply(OP_LDA, 16'h0100);
        do_mul("mul_ovf", 16'h0100, 16'h0000, 1'b1, 1'b1);
        apply(OP_LDA, 16'h0005);
        check_state("lda5", 16'h0005, 1'b0, 1'b1, 1'b0);
        do_mul("mul_zero", 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Abort a MUL in its fifth RUN cycle.
        apply(OP_LDA, 16'h0007);
        operation = OP_MUL;
        data_in   = 16'h0003;
        @(posedge clock);
        @(negedge clock);
        operation = OP_NOP;
        data_in   = 16'h0000;
        check("abort busy run1", 32'(busy), 32'd1);
        repeat (4) @(negedge clock);
        not_reset = 1'b0;
        #1;
        check_state("abort", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        not_reset = 1'b1;
        @(negedge clock);
        apply(OP_LDA, 16'h55AA);
        check_state("post_abort lda", 16'h55AA, 1'b0, 1'b0, 1'b0);
        repeat (20) apply(OP_NOP, 16'h0000);
        check_state("post_abort idle", 16'h55AA, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
